// File: rtl/dcache_tag_array.sv
// Multi-way D-cache tag/state array with registered hit compare, per-set round-robin
// victim selection, and a hardware invalidate sweep after reset and on request.
module dcache_tag_array #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  parameter  int TAG_W = 53,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid_i,
  input  logic [IDX_W-1:0] lk_index_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             ready_o,
  output logic             rsp_valid_o,
  output logic             hit_o,
  output logic [WAY_W-1:0] hit_way_o,
  output logic [WAY_W-1:0] vic_way_o,
  output logic             vic_valid_o,
  output logic             vic_dirty_o,
  output logic [TAG_W-1:0] vic_tag_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WAY_W-1:0] wr_way_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i,
  input  logic             wr_dirty_i,
  input  logic             wr_fill_i,
  input  logic             inv_all_i,
  output logic             busy_o
);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAYS-1:0]  dirty_mem [SETS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAY_W-1:0] rr_mem    [SETS];

  logic             sweep;
  logic             lk_accept;
  logic             wr_accept;
  logic [WAY_W-1:0] wr_way;
  logic [WAY_W-1:0] rr_next;

  logic [WAYS-1:0]  hit_vec;
  logic             hit_d;
  logic [WAY_W-1:0] hit_way_d;
  logic [WAY_W-1:0] vic_way_d;

  assign ready_o   = (state_q == ST_IDLE);
  assign busy_o    = ~ready_o;
  assign sweep     = (state_q == ST_SWEEP);
  assign lk_accept = ready_o & lk_valid_i;
  assign wr_accept = ready_o & wr_en_i;

  // A single-way array has only way 0; pin indices so nothing reads out of range.
  assign wr_way  = (WAYS == 1) ? '0 : wr_way_i;
  assign rr_next = (WAYS == 1) ? '0 : WAY_W'(wr_way_i + WAY_W'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
        if (inv_all_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (inv_all_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: the arrays have no reset; they map onto RAM/flop arrays without a reset
  // network, and the sweep is what makes their valid/dirty/rr contents defined.
  always_ff @(posedge clk) begin
    if (sweep) begin
      valid_mem[cnt_q] <= '0;
      dirty_mem[cnt_q] <= '0;
      rr_mem[cnt_q]    <= '0;
    end else if (wr_accept) begin
      valid_mem[wr_index_i][wr_way] <= wr_valid_i;
      dirty_mem[wr_index_i][wr_way] <= wr_dirty_i;
      tag_mem[wr_index_i][wr_way]   <= wr_tag_i;
      if (wr_fill_i) rr_mem[wr_index_i] <= rr_next;
    end
  end

  // Scan from the top way down so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit_vec   = '0;
    hit_way_d = '0;
    vic_way_d = (WAYS == 1) ? '0 : rr_mem[lk_index_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_mem[lk_index_i][w] && (tag_mem[lk_index_i][w] == lk_tag_i);
      if (hit_vec[w]) hit_way_d = WAY_W'(w);
      if (!valid_mem[lk_index_i][w]) vic_way_d = WAY_W'(w);
    end
    hit_d = |hit_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      hit_way_o   <= '0;
      vic_way_o   <= '0;
      vic_valid_o <= 1'b0;
      vic_dirty_o <= 1'b0;
      vic_tag_o   <= '0;
    end else begin
      rsp_valid_o <= lk_accept;
      if (lk_accept) begin
        hit_o       <= hit_d;
        hit_way_o   <= hit_way_d;
        vic_way_o   <= vic_way_d;
        vic_valid_o <= valid_mem[lk_index_i][vic_way_d];
        vic_dirty_o <= dirty_mem[lk_index_i][vic_way_d];
        vic_tag_o   <= tag_mem[lk_index_i][vic_way_d];
      end
    end
  end

  // A line may live in at most one way of a set.
  assert property (@(posedge clk) disable iff (!rst) lk_accept |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_dcache_tag_array.sv
// Directed bench for dcache_tag_array: a 2-way/64-set instance against a small
// reference model, plus a 4-way/16-set instance for round-robin victim ordering.
module tb_dcache_tag_array;

  typedef struct {
    logic        rv;
    logic        hit;
    logic [2:0]  hit_way;
    logic [2:0]  vic_way;
    logic        vic_valid;
    logic        vic_dirty;
    logic [52:0] vic_tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance: WAYS=2, SETS=64, TAG_W=53
  logic        lk_valid = 1'b0, wr_en = 1'b0, wr_valid = 1'b0, wr_dirty = 1'b0;
  logic        wr_fill = 1'b0, inv_all = 1'b0;
  logic [5:0]  lk_index = '0, wr_index = '0;
  logic [52:0] lk_tag = '0, wr_tag = '0;
  logic        wr_way = 1'b0;
  logic        ready_o, rsp_valid_o, hit_o, hit_way_o, vic_way_o;
  logic        vic_valid_o, vic_dirty_o, busy_o;
  logic [52:0] vic_tag_o;

  dcache_tag_array dut (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid), .lk_index_i(lk_index), .lk_tag_i(lk_tag),
    .ready_o(ready_o), .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .vic_way_o(vic_way_o), .vic_valid_o(vic_valid_o), .vic_dirty_o(vic_dirty_o),
    .vic_tag_o(vic_tag_o),
    .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_way_i(wr_way), .wr_tag_i(wr_tag),
    .wr_valid_i(wr_valid), .wr_dirty_i(wr_dirty), .wr_fill_i(wr_fill),
    .inv_all_i(inv_all), .busy_o(busy_o)
  );

  // Second instance: WAYS=4, SETS=16, TAG_W=20
  logic        lk4_valid = 1'b0, wr4_en = 1'b0, wr4_valid = 1'b0, wr4_dirty = 1'b0;
  logic        wr4_fill = 1'b0, inv4_all = 1'b0;
  logic [3:0]  lk4_index = '0, wr4_index = '0;
  logic [19:0] lk4_tag = '0, wr4_tag = '0;
  logic [1:0]  wr4_way = '0;
  logic        ready4, rsp4_valid, hit4, vic4_valid, vic4_dirty, busy4;
  logic [1:0]  hit4_way, vic4_way;
  logic [19:0] vic4_tag;

  dcache_tag_array #(.WAYS(4), .SETS(16), .TAG_W(20)) dut4 (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk4_valid), .lk_index_i(lk4_index), .lk_tag_i(lk4_tag),
    .ready_o(ready4), .rsp_valid_o(rsp4_valid), .hit_o(hit4), .hit_way_o(hit4_way),
    .vic_way_o(vic4_way), .vic_valid_o(vic4_valid), .vic_dirty_o(vic4_dirty),
    .vic_tag_o(vic4_tag),
    .wr_en_i(wr4_en), .wr_index_i(wr4_index), .wr_way_i(wr4_way), .wr_tag_i(wr4_tag),
    .wr_valid_i(wr4_valid), .wr_dirty_i(wr4_dirty), .wr_fill_i(wr4_fill),
    .inv_all_i(inv4_all), .busy_o(busy4)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t q[$];
  rsp_t q4[$];

  // Reference model of the default instance
  logic        m_valid [64][2];
  logic        m_dirty [64][2];
  logic [52:0] m_tag   [64][2];
  int          m_rr    [64];
  int          m_sweep = 0;
  bit          inv_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
    end
  endtask

  task automatic compare_rsp(input string name, input rsp_t obs, input rsp_t exp);
    check({name, ".rsp_valid"}, 64'(obs.rv), 64'(exp.rv));
    if (exp.rv) begin
      check({name, ".hit"},       64'(obs.hit),       64'(exp.hit));
      check({name, ".hit_way"},   64'(obs.hit_way),   64'(exp.hit_way));
      check({name, ".vic_way"},   64'(obs.vic_way),   64'(exp.vic_way));
      check({name, ".vic_valid"}, 64'(obs.vic_valid), 64'(exp.vic_valid));
      check({name, ".vic_dirty"}, 64'(obs.vic_dirty), 64'(exp.vic_dirty));
      if (exp.vic_valid) check({name, ".vic_tag"}, 64'(obs.vic_tag), 64'(exp.vic_tag));
    end
  endtask

  // One clock: sample #1 after the edge, score, then release one-shot inputs.
  task automatic tick();
    rsp_t e, o;
    @(posedge clk);
    #1;
    if (inv_pend) begin
      inv_pend = 1'b0;
      m_sweep  = 64;
      model_clear();
    end else if (m_sweep > 0) begin
      m_sweep--;
    end
    check("ready", 64'(ready_o), 64'(m_sweep == 0));
    check("busy",  64'(busy_o),  64'(m_sweep != 0));

    e = '{rv: 1'b0, hit: 1'b0, hit_way: 3'd0, vic_way: 3'd0, vic_valid: 1'b0,
          vic_dirty: 1'b0, vic_tag: 53'd0};
    if (q.size() > 0) e = q.pop_front();
    o = '{rv: rsp_valid_o, hit: hit_o, hit_way: {2'b0, hit_way_o}, vic_way: {2'b0, vic_way_o},
          vic_valid: vic_valid_o, vic_dirty: vic_dirty_o, vic_tag: vic_tag_o};
    compare_rsp("rsp", o, e);

    e = '{rv: 1'b0, hit: 1'b0, hit_way: 3'd0, vic_way: 3'd0, vic_valid: 1'b0,
          vic_dirty: 1'b0, vic_tag: 53'd0};
    if (q4.size() > 0) e = q4.pop_front();
    o = '{rv: rsp4_valid, hit: hit4, hit_way: {1'b0, hit4_way}, vic_way: {1'b0, vic4_way},
          vic_valid: vic4_valid, vic_dirty: vic4_dirty, vic_tag: {33'b0, vic4_tag}};
    compare_rsp("rsp4", o, e);

    lk_valid = 1'b0; wr_en = 1'b0; wr_fill = 1'b0; inv_all = 1'b0;
    lk4_valid = 1'b0; wr4_en = 1'b0; wr4_fill = 1'b0;
  endtask

  // Expectation is taken from the model before any same-cycle write (read-first).
  task automatic lookup(input int idx, input logic [52:0] tag);
    rsp_t e;
    int   hw, vic;
    bit   h;
    lk_valid = 1'b1; lk_index = 6'(idx); lk_tag = tag;
    e = '{rv: 1'b0, hit: 1'b0, hit_way: 3'd0, vic_way: 3'd0, vic_valid: 1'b0,
          vic_dirty: 1'b0, vic_tag: 53'd0};
    if (m_sweep == 0) begin
      h = 1'b0; hw = 0; vic = m_rr[idx];
      for (int w = 1; w >= 0; w--) begin
        if (m_valid[idx][w] && m_tag[idx][w] == tag) begin h = 1'b1; hw = w; end
        if (!m_valid[idx][w]) vic = w;
      end
      e = '{rv: 1'b1, hit: h, hit_way: 3'(hw), vic_way: 3'(vic),
            vic_valid: m_valid[idx][vic], vic_dirty: m_dirty[idx][vic], vic_tag: m_tag[idx][vic]};
    end
    q.push_back(e);
  endtask

  task automatic write(input int idx, input int way, input logic [52:0] tag,
                       input bit v, input bit d, input bit fill);
    wr_en = 1'b1; wr_index = 6'(idx); wr_way = 1'(way); wr_tag = tag;
    wr_valid = v; wr_dirty = d; wr_fill = fill;
    if (m_sweep == 0) begin
      m_valid[idx][way] = v;
      m_dirty[idx][way] = d;
      m_tag[idx][way]   = tag;
      if (fill) m_rr[idx] = (way + 1) % 2;
    end
  endtask

  task automatic inv();
    inv_all = 1'b1;
    if (m_sweep == 0) inv_pend = 1'b1;
  endtask

  task automatic do_reset(input bit immediate);
    rst = 1'b0;
    lk_valid = 1'b0; wr_en = 1'b0; wr_fill = 1'b0; inv_all = 1'b0;
    lk4_valid = 1'b0; wr4_en = 1'b0; wr4_fill = 1'b0;
    q.delete(); q4.delete(); inv_pend = 1'b0;
    #1;
    if (immediate) begin
      check("async_rst.busy",  64'(busy_o),  64'd1);
      check("async_rst.ready", 64'(ready_o), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",     64'(ready_o),     64'd0);
    check("rst.busy",      64'(busy_o),      64'd1);
    check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst.hit",       64'(hit_o),       64'd0);
    check("rst.hit_way",   64'(hit_way_o),   64'd0);
    check("rst.vic_way",   64'(vic_way_o),   64'd0);
    check("rst.vic_valid", 64'(vic_valid_o), 64'd0);
    check("rst.vic_dirty", 64'(vic_dirty_o), 64'd0);
    check("rst.vic_tag",   64'(vic_tag_o),   64'd0);
    rst = 1'b1;
    m_sweep = 64;
    model_clear();
    check("release.ready", 64'(ready_o), 64'd0);
    for (int c = 0; c < 64; c++) tick();
  endtask

  initial begin
    // 1: reset release, 64-cycle sweep, first lookup misses on an empty set
    do_reset(1'b0);
    lookup(5, 53'h123); tick();

    // 2: fill one way, hit it, victim is the still-invalid way 0
    write(5, 1, 53'hABC, 1'b1, 1'b1, 1'b1); tick();
    lookup(5, 53'hABC); tick();

    // 3: full set, round-robin victim and writeback state
    write(7, 0, 53'h10, 1'b1, 1'b1, 1'b1); tick();
    write(7, 1, 53'h11, 1'b1, 1'b0, 1'b1); tick();
    lookup(7, 53'h99); tick();
    write(7, 0, 53'h10, 1'b1, 1'b1, 1'b1); tick();
    lookup(7, 53'h99); tick();

    // 4: same-cycle lookup and write are read-first
    lookup(9, 53'h20); write(9, 0, 53'h20, 1'b1, 1'b0, 1'b0); tick();
    lookup(9, 53'h20); tick();

    // 5: invalidate sweep; lookup in the pulse cycle still answers, sweep drops traffic
    for (int s = 20; s < 24; s++) begin
      write(s, s % 2, 53'h1000 + 53'(s), 1'b1, 1'b0, 1'b1); tick();
    end
    lookup(20, 53'h1014); inv(); tick();
    for (int c = 0; c < 64; c++) begin
      if (c % 16 == 3) lookup(5, 53'hABC);
      if (c == 40) write(0, 0, 53'h55, 1'b1, 1'b1, 1'b1);
      tick();
    end
    lookup(5, 53'hABC);  tick();
    lookup(7, 53'h10);   tick();
    lookup(20, 53'h1014); tick();
    lookup(21, 53'h1015); tick();
    lookup(0, 53'h55);   tick();
    lookup(9, 53'h20);   tick();

    // 6: reset in the middle of a sweep restarts a full sweep
    write(5, 0, 53'h77, 1'b1, 1'b0, 1'b1); tick();
    inv(); tick();
    repeat (20) tick();
    do_reset(1'b1);
    lookup(5, 53'h77); tick();

    // 4-way instance: misses walk invalid ways 0..3, then the round-robin pointer wraps to 0
    for (int k = 0; k < 5; k++) begin
      rsp_t e;
      lk4_valid = 1'b1; lk4_index = 4'd3; lk4_tag = 20'h999;
      e = '{rv: 1'b1, hit: 1'b0, hit_way: 3'd0, vic_way: 3'(k % 4),
            vic_valid: (k == 4), vic_dirty: 1'b0, vic_tag: 53'h100};
      q4.push_back(e);
      tick();
      if (k < 4) begin
        wr4_en = 1'b1; wr4_index = 4'd3; wr4_way = 2'(k); wr4_tag = 20'h100 + 20'(k);
        wr4_valid = 1'b1; wr4_dirty = 1'b0; wr4_fill = 1'b1;
        tick();
      end
    end
    lk4_valid = 1'b1; lk4_index = 4'd3; lk4_tag = 20'h102;
    q4.push_back('{rv: 1'b1, hit: 1'b1, hit_way: 3'd2, vic_way: 3'd0, vic_valid: 1'b1,
                   vic_dirty: 1'b0, vic_tag: 53'h100});
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
